vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
Shares the single read/write port of one `sram` instance (sprite/background VRAM) among NREQ requesters, such as display scanout, sprite renderers and a CPU/loader.
- One access is granted per clock: fixed-priority-0 override (optional), then round-robin.
- The block drives the SRAM address, write-enable and write-data.
- Read data returns a fixed latency later, tagged back to the requester that issued it.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_WIDTH, 10, SRAM address width
DATA_WIDTH, 8, SRAM data width
RD_LATENCY, 1, clocks from grant cycle to read data on i_mem_rdata (1..4); matches the `sram` registered output
HIPRI0, 1, 1 = requester 0 (scanout) always wins when requesting; 0 = pure round-robin

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
i_req  input  NREQ  per-requester access request, level
i_we  input  NREQ  per-requester write (1) / read (0) qualifier
i_addr  input  NREQ*ADDR_WIDTH  packed addresses, requester k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
i_wdata  input  NREQ*DATA_WIDTH  packed write data, same packing
o_gnt  output  NREQ  one-hot grant, combinational in the request cycle
o_rvalid  output  NREQ  one-hot read-data-valid
o_rdata  output  DATA_WIDTH  read data, shared by all requesters
o_mem_addr  output  ADDR_WIDTH  to sram i_addr
o_mem_write  output  1  to sram i_write
o_mem_wdata  output  DATA_WIDTH  to sram i_data
i_mem_rdata  input  DATA_WIDTH  from sram o_data

Behaviour:
Reset (rst_n low, asynchronous):
- RR pointer = 0.
- Read-tag pipeline cleared, so o_rvalid = 0.
- o_rdata = 0 once registered.
- o_gnt and o_mem_* depend only on inputs. While reset is held, o_gnt = 0, o_mem_write = 0, o_mem_addr = 0 and o_mem_wdata = 0.

Arbitration (each cycle, combinational from i_req and the pointer):
- If HIPRI0=1 and i_req[0]=1, grant requester 0.
- Otherwise, grant the first k with i_req[k]=1, searching ptr, ptr+1, …, wrapping modulo NREQ.
- At most one o_gnt bit is set. No request means o_gnt = 0.

Pointer update (rising edge):
- If the grant went to k via round-robin, ptr <= (k+1) mod NREQ.
- If the grant went to 0 via HIPRI0 override, or there was no grant, ptr is unchanged.

Port mux:
- With a grant to k: o_mem_addr = addr[k], o_mem_write = i_we[k], o_mem_wdata = wdata[k].
- With no grant: o_mem_addr = 0, o_mem_write = 0, o_mem_wdata = 0.

Requester handshake:
- A requester holds i_req, i_we, i_addr and i_wdata stable until it sees o_gnt[k]=1. The transfer completes on that edge.
- The requester may deassert i_req or issue a new access in the following cycle; back-to-back grants to the same requester are legal.
- Withdrawing i_req before grant is legal; no access occurs.

Reads:
- Tag pipeline of depth RD_LATENCY carries {valid, requester index} for each granted read. Writes push no valid.
- A read granted in cycle t gives o_rvalid[k]=1 for exactly one cycle at t+RD_LATENCY, with o_rdata = i_mem_rdata in that cycle (passthrough, no extra latency).
- Whenever no rvalid bit is set, o_rdata holds its last value.

Read-after-write:
- A write granted at t followed by a read of the same address at t+1 returns the new data. The SRAM ordering guarantees this; the arbiter adds no bypass.

Reset mid-operation:
- In-flight reads are discarded and no o_rvalid is produced for them.
- The pointer returns to 0.

Throughput: one access per clock. Reads and writes are fully pipelined with no bubbles.

Test Plan:
- Single reader: req[2]=1, we=0, addr[2]=0x05, memory[5]=0xA7 → gnt=0100 the same cycle; next cycle rvalid=0100, rdata=0xA7; ptr becomes 3.
- Round-robin fairness: HIPRI0=0, req=1111 held for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; each rvalid one cycle after its grant, matching its address's data.
- Priority override: HIPRI0=1, req=1011 continuously for 4 cycles → gnt=0001 every cycle, ptr stays 1. Then drop req[0] → next grants are 1, 3, 1 in that order.
- Write then read: req[1] write addr 0x3FF data 0x5C, granted at t; req[1] read of 0x3FF at t+1 → rvalid[1] at t+2 with rdata=0x5C; o_mem_write=1 only at t.
- Latency parameter: RD_LATENCY=3, with the SRAM model delayed to match; reads granted to requesters 0, 2 and 3 on consecutive cycles → rvalid = 0001, 0100, 1000 on cycles t+3, t+4, t+5 with the matching data.
- Async reset mid-read: grant a read at t, assert rst_n=0 between edges → o_rvalid stays 0 and o_gnt=0 immediately. After release, the first grant with req=1111 and HIPRI0=0 goes to requester 0.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Shares one SRAM port among NREQ requesters: optional requester-0 priority, then round-robin.
// Grant is combinational (0 cycles); read data tagged back RD_LATENCY clocks later; losers simply hold their request.
module vram_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int HIPRI0     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ-1:0]            i_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] i_wdata,
  output logic [NREQ-1:0]            o_gnt,
  output logic [NREQ-1:0]            o_rvalid,
  output logic [DATA_WIDTH-1:0]      o_rdata,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr,
  output logic                       o_mem_write,
  output logic [DATA_WIDTH-1:0]      o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]      i_mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]         ptr;
  logic                  gnt_vld;
  logic                  gnt_rr;
  logic [IW-1:0]         gnt_idx;
  logic [RD_LATENCY-1:0] tag_vld;
  logic [IW-1:0]         tag_idx [RD_LATENCY];
  logic [DATA_WIDTH-1:0] rdata_q;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Search farthest-to-nearest so the candidate closest to ptr is the one left standing.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_rr  = 1'b0;
    gnt_idx = '0;
    if (rst_n) begin
      if (HIPRI0 != 0 && i_req[0]) begin
        gnt_vld = 1'b1;
      end else begin
        for (int o = NREQ - 1; o >= 0; o--) begin
          if (i_req[wrap_idx(ptr, o)]) begin
            gnt_vld = 1'b1;
            gnt_rr  = 1'b1;
            gnt_idx = wrap_idx(ptr, o);
          end
        end
      end
    end
  end

  always_comb begin
    o_gnt       = '0;
    o_mem_addr  = '0;
    o_mem_write = 1'b0;
    o_mem_wdata = '0;
    if (gnt_vld) begin
      o_gnt[gnt_idx] = 1'b1;
      o_mem_addr     = i_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      o_mem_write    = i_we[gnt_idx];
      o_mem_wdata    = i_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Priority-0 wins do not advance the pointer, so the round-robin order resumes where it left off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_vld && gnt_rr) begin
      ptr <= wrap_idx(gnt_idx, 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld[0] <= gnt_vld && !i_we[gnt_idx];
      tag_idx[0] <= gnt_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_comb begin
    o_rvalid = '0;
    if (tag_vld[RD_LATENCY-1]) o_rvalid[tag_idx[RD_LATENCY-1]] = 1'b1;
  end

  // Read data passes straight through in its valid cycle and is held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (tag_vld[RD_LATENCY-1]) begin
      rdata_q <= i_mem_rdata;
    end
  end

  assign o_rdata = tag_vld[RD_LATENCY-1] ? i_mem_rdata : rdata_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Drives three arbiter configurations with one directed stream and checks each against a behavioural model.
module tb_vram_port_arbiter;

  localparam int NC     = 3;
  localparam int HP[NC]  = '{1, 0, 1};
  localparam int LAT[NC] = '{1, 1, 3};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  we = '0;
  logic [39:0] addr = '0;
  logic [31:0] wdata = '0;
  int          stp = 0;

  logic [3:0] gnt       [NC];
  logic [3:0] rvalid    [NC];
  logic [7:0] rdata     [NC];
  logic [9:0] mem_addr  [NC];
  logic       mem_write [NC];
  logic [7:0] mem_wdata [NC];
  logic [7:0] mem_rdata [NC];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    logic [31:0] v;
    v = a;
    return (a == 5) ? 8'hA7 : (v[7:0] ^ 8'h3C);
  endfunction

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    logic [7:0] mem  [1024];
    logic [7:0] pipe [4];

    initial for (int a = 0; a < 1024; a++) mem[a] = init_val(a);

    // Registered-output SRAM stretched to the configured read latency.
    always @(posedge clk) begin
      if (mem_write[g]) mem[mem_addr[g]] <= mem_wdata[g];
      pipe[0] <= mem[mem_addr[g]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[LAT[g]-1];

    vram_port_arbiter #(
      .NREQ(4), .ADDR_WIDTH(10), .DATA_WIDTH(8), .RD_LATENCY(LAT[g]), .HIPRI0(HP[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (req),
      .i_we       (we),
      .i_addr     (addr),
      .i_wdata    (wdata),
      .o_gnt      (gnt[g]),
      .o_rvalid   (rvalid[g]),
      .o_rdata    (rdata[g]),
      .o_mem_addr (mem_addr[g]),
      .o_mem_write(mem_write[g]),
      .o_mem_wdata(mem_wdata[g]),
      .i_mem_rdata(mem_rdata[g])
    );
  end

  // Model state: pointer, memory image, read-return schedule keyed by cycle, held read data.
  int         m_ptr  [NC];
  logic [7:0] m_mem  [NC][1024];
  bit         s_vld  [NC][8];
  int         s_idx  [NC][8];
  logic [7:0] s_dat  [NC][8];
  logic [7:0] m_hold [NC];
  int         cyc = 0;

  initial begin
    for (int c = 0; c < NC; c++) begin
      m_ptr[c]  = 0;
      m_hold[c] = 8'h00;
      for (int a = 0; a < 1024; a++) m_mem[c][a] = init_val(a);
      for (int s = 0; s < 8; s++) s_vld[c][s] = 1'b0;
    end
  end

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d step%0d: got %0h, expected %0h", nm, c, stp, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int         gi, k, slot, ns;
    bit         rr;
    logic [3:0] eg, erv;
    logic [9:0] ea;
    logic [7:0] ed;
    logic       ew;
    slot = cyc % 8;
    for (int c = 0; c < NC; c++) begin
      gi = -1; rr = 1'b0; eg = '0; erv = '0; ea = '0; ed = '0; ew = 1'b0;
      if (!rst_n) begin
        m_ptr[c]  = 0;
        m_hold[c] = 8'h00;
        for (int s = 0; s < 8; s++) s_vld[c][s] = 1'b0;
      end else begin
        if (s_vld[c][slot]) begin
          erv[s_idx[c][slot]] = 1'b1;
          m_hold[c] = s_dat[c][slot];
          s_vld[c][slot] = 1'b0;
        end
        if (HP[c] != 0 && req[0]) begin
          gi = 0;
        end else begin
          for (int o = 0; o < 4; o++) begin
            k = (m_ptr[c] + o) % 4;
            if (gi < 0 && req[k]) begin
              gi = k;
              rr = 1'b1;
            end
          end
        end
        if (gi >= 0) begin
          eg[gi] = 1'b1;
          ea = addr[gi*10 +: 10];
          ew = we[gi];
          ed = wdata[gi*8 +: 8];
        end
      end
      chk("gnt", c, 32'(gnt[c]), 32'(eg));
      chk("mem_addr", c, 32'(mem_addr[c]), 32'(ea));
      chk("mem_write", c, 32'(mem_write[c]), 32'(ew));
      chk("mem_wdata", c, 32'(mem_wdata[c]), 32'(ed));
      chk("rvalid", c, 32'(rvalid[c]), 32'(erv));
      chk("rdata", c, 32'(rdata[c]), 32'(m_hold[c]));
      if (gi >= 0) begin
        if (ew) begin
          m_mem[c][ea] = ed;
        end else begin
          ns = (cyc + LAT[c]) % 8;
          s_vld[c][ns] = 1'b1;
          s_idx[c][ns] = gi;
          s_dat[c][ns] = m_mem[c][ea];
        end
        if (rr) m_ptr[c] = (gi + 1) % 4;
      end
    end
    cyc++;

    // Hand-computed expectations that pin the model to the directed scenarios.
    if (stp == 1) begin
      chk("lit_rst_gnt", 1, 32'(gnt[1]), 32'h0);
      chk("lit_rst_rvalid", 1, 32'(rvalid[1]), 32'h0);
      chk("lit_rst_rdata", 1, 32'(rdata[1]), 32'h0);
      chk("lit_rst_write", 1, 32'(mem_write[1]), 32'h0);
    end
    if (stp == 2) begin
      chk("lit_single_gnt", 1, 32'(gnt[1]), 32'h4);
      chk("lit_single_gnt", 0, 32'(gnt[0]), 32'h4);
    end
    if (stp == 3) begin
      chk("lit_single_rvalid", 1, 32'(rvalid[1]), 32'h4);
      chk("lit_single_rdata", 1, 32'(rdata[1]), 32'hA7);
      chk("lit_ptr3_gnt", 1, 32'(gnt[1]), 32'h8);
      chk("lit_hipri_gnt", 0, 32'(gnt[0]), 32'h1);
    end
    if (stp == 4) begin
      chk("lit_midrst_rvalid", 1, 32'(rvalid[1]), 32'h0);
      chk("lit_midrst_gnt", 1, 32'(gnt[1]), 32'h0);
    end
    if (stp == 5) chk("lit_discard_rvalid", 2, 32'(rvalid[2]), 32'h0);
    if (stp >= 5 && stp <= 12) begin
      chk("lit_rr_gnt", 1, 32'(gnt[1]), 32'h1 << ((stp - 5) % 4));
      chk("lit_rr_hipri_gnt", 0, 32'(gnt[0]), 32'h1);
    end
    if (stp >= 13 && stp <= 16) chk("lit_override_gnt", 0, 32'(gnt[0]), 32'h1);
    if (stp == 17) chk("lit_after_override", 0, 32'(gnt[0]), 32'h2);
    if (stp == 18) chk("lit_after_override", 0, 32'(gnt[0]), 32'h8);
    if (stp == 19) chk("lit_after_override", 0, 32'(gnt[0]), 32'h2);
    if (stp == 20) begin
      chk("lit_wr_write", 1, 32'(mem_write[1]), 32'h1);
      chk("lit_wr_addr", 1, 32'(mem_addr[1]), 32'h3FF);
      chk("lit_wr_wdata", 1, 32'(mem_wdata[1]), 32'h5C);
    end
    if (stp == 21) begin
      chk("lit_rd_write", 1, 32'(mem_write[1]), 32'h0);
      chk("lit_rd_gnt", 1, 32'(gnt[1]), 32'h2);
    end
    if (stp == 22) begin
      chk("lit_raw_rvalid", 1, 32'(rvalid[1]), 32'h2);
      chk("lit_raw_rdata", 1, 32'(rdata[1]), 32'h5C);
    end
    if (stp == 25) begin
      chk("lit_lat3_rvalid", 2, 32'(rvalid[2]), 32'h1);
      chk("lit_lat3_rdata", 2, 32'(rdata[2]), 32'h5C);
    end
    if (stp == 26) chk("lit_lat3_rvalid", 2, 32'(rvalid[2]), 32'h4);
    if (stp == 27) chk("lit_lat3_rvalid", 2, 32'(rvalid[2]), 32'h8);
  end

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] w,
                      input logic [39:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    stp++;
    rst_n = r;
    req   = rq;
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
  endtask

  initial begin
    step(1'b0, 4'b1111, 4'b0000, '0, '0);                                        // 1
    step(1'b1, 4'b0100, 4'b0000, {10'h000, 10'h005, 10'h000, 10'h000}, '0);      // 2
    step(1'b1, 4'b1001, 4'b0000, {10'h013, 10'h000, 10'h000, 10'h010}, '0);      // 3
    step(1'b0, 4'b1111, 4'b0000, {10'h013, 10'h000, 10'h000, 10'h010}, '0);      // 4
    for (int i = 0; i < 8; i++)                                                 // 5..12
      step(1'b1, 4'b1111, 4'b0000, {10'h023, 10'h022, 10'h021, 10'h020}, '0);
    for (int i = 0; i < 4; i++)                                                 // 13..16
      step(1'b1, 4'b1011, 4'b0000, {10'h043, 10'h042, 10'h041, 10'h040}, '0);
    for (int i = 0; i < 3; i++)                                                 // 17..19
      step(1'b1, 4'b1010, 4'b0000, {10'h043, 10'h042, 10'h041, 10'h040}, '0);
    step(1'b1, 4'b0010, 4'b0010, {10'h000, 10'h000, 10'h3FF, 10'h000},
         {8'h00, 8'h00, 8'h5C, 8'h00});                                          // 20
    step(1'b1, 4'b0010, 4'b0000, {10'h000, 10'h000, 10'h3FF, 10'h000}, '0);      // 21
    step(1'b1, 4'b0001, 4'b0000, {10'h000, 10'h000, 10'h000, 10'h3FF}, '0);      // 22
    step(1'b1, 4'b0100, 4'b0000, {10'h000, 10'h032, 10'h000, 10'h000}, '0);      // 23
    step(1'b1, 4'b1000, 4'b0000, {10'h033, 10'h000, 10'h000, 10'h000}, '0);      // 24
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 4'b0000, '0, '0);           // 25..27
    for (int i = 0; i < 6; i++) begin                                           // 28..33
      logic [7:0] b;
      b = 8'(i * 16);
      step(1'b1, 4'b1111, (i < 3) ? 4'b1111 : 4'b0000,
           {10'h053, 10'h052, 10'h051, 10'h050},
           {b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, 4'b0000, '0, '0);           // 34..37
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
